icon_bank_writer: RTL

// Loads a 16x16, 12-bit-per-pixel bot icon into one half of a double-buffered icon RAM.
// The icon display path reads the RAM with address {bank, row[3:0], col[3:0]}.

---
 rtl/icon_bank_writer.sv | 99 +++++++++
 1 files changed

// File: rtl/icon_bank_writer.sv
// Streams a 16x16 icon into the back half of a double-buffered icon RAM.
// The finished bank becomes visible to the display only on a vertical-blank rising edge.
module icon_bank_writer #(
    parameter int ICON_DIM = 16,
    parameter int DIM_BITS = 4,
    parameter int PIX_W    = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PIX_W-1:0]        pixData,
    input  logic                    pixValid,
    output logic                    pixReady,
    input  logic                    vBlank,
    output logic                    wrEn,
    output logic [2*DIM_BITS:0]     wrAddr,
    output logic [PIX_W-1:0]        wrData,
    output logic                    rdBank,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_VB} state_t;

    localparam logic [DIM_BITS-1:0] LAST = DIM_BITS'(ICON_DIM - 1);

    state_t              state;
    logic                wrBank;
    logic [DIM_BITS-1:0] row;
    logic [DIM_BITS-1:0] col;
    logic                vBlankD;
    logic                accept;
    logic                lastPix;

    always_comb begin
        accept  = pixValid & pixReady;
        lastPix = accept && (row == LAST) && (col == LAST);
    end

    // vBlankD is only consulted in WAIT_VB, so it tracks vBlank even through reset.
    always_ff @(posedge clk) begin
        vBlankD <= vBlank;
        if (reset) begin
            state    <= IDLE;
            wrBank   <= 1'b0;
            row      <= '0;
            col      <= '0;
            pixReady <= 1'b0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            rdBank   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wrEn <= accept;
            done <= 1'b0;
            if (accept) begin
                wrAddr <= {wrBank, row, col};
                wrData <= pixData;
                col    <= col + 1'b1;
                if (col == LAST)
                    row <= row + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        wrBank   <= ~rdBank;
                        row      <= '0;
                        col      <= '0;
                        state    <= LOAD;
                        busy     <= 1'b1;
                        pixReady <= 1'b1;
                    end
                end
                LOAD: begin
                    if (lastPix) begin
                        state    <= WAIT_VB;
                        pixReady <= 1'b0;
                    end
                end
                WAIT_VB: begin
                    if (vBlank && !vBlankD) begin
                        rdBank <= wrBank;
                        done   <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    pixReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
